vga_scan_gen: RTL and testbench

// Raster scan timing generator: the producing end of the (hsp, vsp) pixel-coordinate

---
 rtl/vga_scan_gen.sv | 141 ++++++++++++++
 tb/tb_vga_scan_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// Purpose: raster scan timing generator (pixel coordinates, VGA syncs, blanking, line/frame ticks).
// Latency: all outputs registered; they lag the internal h/v counters by one clk and are mutually aligned.
// Backpressure: none; free-running, and pix_stb marks the first clk of each new coordinate.
module vga_scan_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hsp,
    output logic [9:0] vsp,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_stb,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Decode boundaries are 11 bits wide so a sync pulse ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYN_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYN_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYN_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYN_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             h_wrap_q, h_wrap_d;
    logic             v_wrap_q, v_wrap_d;
    logic [9:0]       hsp_q, hsp_d;
    logic [9:0]       vsp_q, vsp_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             pix_stb_q, pix_stb_d;
    logic             line_tick_q, line_tick_d;
    logic             frame_tick_q, frame_tick_d;

    logic             adv;
    logic             h_last;
    logic             v_last;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;

    // Next-state for the divider and raster counters, plus the registered output decodes.
    always_comb begin
        adv    = (div_cnt_q == DIV_LAST);
        h_last = (h_cnt_q == H_LAST);
        v_last = (v_cnt_q == V_LAST);
        h_ext  = {1'b0, h_cnt_q};
        v_ext  = {1'b0, v_cnt_q};

        div_cnt_d = adv ? '0 : div_cnt_q + 1'b1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (adv) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end

        // Wrap flags remember that the counters just rolled over, so the tick lands on the
        // same clk the output stage first shows the wrapped coordinate. Reset clears them,
        // which is why the (0,0) shown after reset never carries a tick.
        h_wrap_d = adv && h_last;
        v_wrap_d = adv && h_last && v_last;

        hsp_d        = h_cnt_q;
        vsp_d        = v_cnt_q;
        hsync_d      = !((h_ext >= H_SYN_BEG) && (h_ext < H_SYN_END));
        vsync_d      = !((v_ext >= V_SYN_BEG) && (v_ext < V_SYN_END));
        video_on_d   = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        pix_stb_d    = (div_cnt_q == '0);
        line_tick_d  = h_wrap_q;
        frame_tick_d = v_wrap_q;
    end

    // State and output registers; reset wins over any wrap or tick on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            h_wrap_q     <= 1'b0;
            v_wrap_q     <= 1'b0;
            hsp_q        <= '0;
            vsp_q        <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            video_on_q   <= 1'b0;
            pix_stb_q    <= 1'b0;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            h_wrap_q     <= h_wrap_d;
            v_wrap_q     <= v_wrap_d;
            hsp_q        <= hsp_d;
            vsp_q        <= vsp_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            pix_stb_q    <= pix_stb_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hsp        = hsp_q;
    assign vsp        = vsp_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign pix_stb    = pix_stb_q;
    assign line_tick  = line_tick_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Purpose: checks three scan generators: default timing, a shrunken raster for whole frames, and CLK_DIV=1.
// Latency: expected timing events are queued up front; a negedge monitor pops one per observed event.
// Backpressure: none; events are keyed by the sample index since the last reset release.
module tb_vga_scan_gen;

    typedef enum logic [3:0] {
        EV_START, EV_LINE, EV_FRAME, EV_VON, EV_VOFF,
        EV_HS_LO, EV_HS_HI, EV_VS_LO, EV_VS_HI
    } ev_kind_t;

    typedef struct packed {
        ev_kind_t    kind;
        logic [31:0] k;
        logic [9:0]  h;
        logic [9:0]  v;
    } ev_t;

    logic clk;
    logic rst0;
    logic rst1;

    logic [9:0] hsp_w [3];
    logic [9:0] vsp_w [3];
    logic       hs_w  [3];
    logic       vs_w  [3];
    logic       von_w [3];
    logic       stb_w [3];
    logic       lt_w  [3];
    logic       ft_w  [3];

    ev_t q0[$];
    ev_t q1[$];
    ev_t q2[$];

    int checks = 0;
    int errors = 0;

    bit         rst_s  [3] = '{1'b1, 1'b1, 1'b1};
    bit         in_rst [3] = '{1'b1, 1'b1, 1'b1};
    int         k_m    [3] = '{0, 0, 0};
    int         hold_m [3] = '{0, 0, 0};
    int         lim    [3] = '{3900, 1460, 2410};
    int         div_of [3] = '{2, 2, 1};
    logic       prev_von [3];
    logic       prev_hs  [3];
    logic       prev_vs  [3];
    logic [9:0] prev_h   [3];

    vga_scan_gen u_dflt (
        .clk(clk), .rst(rst0),
        .hsp(hsp_w[0]), .vsp(vsp_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]),
        .video_on(von_w[0]), .pix_stb(stb_w[0]), .line_tick(lt_w[0]), .frame_tick(ft_w[0])
    );

    // 24 x 15 raster: 48 clk per line, 720 clk per frame.
    vga_scan_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .clk(clk), .rst(rst1),
        .hsp(hsp_w[1]), .vsp(vsp_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]),
        .video_on(von_w[1]), .pix_stb(stb_w[1]), .line_tick(lt_w[1]), .frame_tick(ft_w[1])
    );

    vga_scan_gen #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst1),
        .hsp(hsp_w[2]), .vsp(vsp_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]),
        .video_on(von_w[2]), .pix_stb(stb_w[2]), .line_tick(lt_w[2]), .frame_tick(ft_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record what reset level each DUT saw on the edge its outputs now reflect.
    always @(posedge clk) begin
        rst_s[0] <= rst0;
        rst_s[1] <= rst1;
        rst_s[2] <= rst1;
    end

    task automatic chk(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h", name, d, act, exp);
        end
    endtask

    task automatic push(input int d, input ev_kind_t kind, input int k, input int h, input int v);
        ev_t e;
        e.kind = kind;
        e.k    = 32'(k);
        e.h    = 10'(h);
        e.v    = 10'(v);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Queue the expected events for lines 0..n-1 plus the line-start events of line n.
    // Clock offsets are hand-derived from the porch/sync widths of each instance.
    task automatic gen(input int d, input int n, input int line_clk,
                       input int voff_clk, input int hslo_clk, input int hshi_clk,
                       input int voff_h, input int hslo_h, input int hshi_h,
                       input int vact, input int vs_lo, input int vs_hi, input int vtot);
        for (int ln = 0; ln <= n; ln++) begin
            int v;
            int base;
            v    = ln % vtot;
            base = ln * line_clk;
            if (ln == 0) begin
                push(d, EV_START, base, 0, 0);
            end else begin
                push(d, EV_LINE, base, 0, v);
                if (v == 0) push(d, EV_FRAME, base, 0, 0);
                if (v < vact) push(d, EV_VON, base, 0, v);
                if (v == vs_lo) push(d, EV_VS_LO, base, 0, v);
                if (v == vs_hi) push(d, EV_VS_HI, base, 0, v);
            end
            if (ln < n) begin
                if (v < vact) push(d, EV_VOFF, base + voff_clk, voff_h, v);
                push(d, EV_HS_LO, base + hslo_clk, hslo_h, v);
                push(d, EV_HS_HI, base + hshi_clk, hshi_h, v);
            end
        end
    endtask

    task automatic pop_cmp(input int d, input ev_kind_t kind, input logic [9:0] h, input logic [9:0] v);
        ev_t a;
        ev_t e;
        int  sz;
        a.kind = kind;
        a.k    = 32'(k_m[d]);
        a.h    = h;
        a.v    = v;
        case (d)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event dut%0d actual=%h required=none", d, a);
        end else begin
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk(d, "event", 64'(a), 64'(e));
        end
    endtask

    task automatic monitor(input int d);
        logic [9:0] h;
        logic [9:0] v;
        h = hsp_w[d];
        v = vsp_w[d];
        if (rst_s[d]) begin
            chk(d, "reset_state",
                64'({h, v, hs_w[d], vs_w[d], von_w[d], stb_w[d], lt_w[d], ft_w[d]}),
                64'({10'd0, 10'd0, 6'b110000}));
            in_rst[d] = 1'b1;
        end else if (in_rst[d]) begin
            in_rst[d] = 1'b0;
            k_m[d]    = 0;
            hold_m[d] = 1;
            pop_cmp(d, EV_START, h, v);
            chk(d, "start_flags", 64'({von_w[d], stb_w[d], lt_w[d], ft_w[d]}), 64'(4'b1100));
        end else begin
            k_m[d]++;
            if (k_m[d] <= lim[d]) begin
                if (lt_w[d]) pop_cmp(d, EV_LINE, h, v);
                if (ft_w[d]) pop_cmp(d, EV_FRAME, h, v);
                if (von_w[d] && !prev_von[d]) pop_cmp(d, EV_VON, h, v);
                if (!von_w[d] && prev_von[d]) pop_cmp(d, EV_VOFF, h, v);
                if (!hs_w[d] && prev_hs[d]) pop_cmp(d, EV_HS_LO, h, v);
                if (hs_w[d] && !prev_hs[d]) pop_cmp(d, EV_HS_HI, h, v);
                if (!vs_w[d] && prev_vs[d]) pop_cmp(d, EV_VS_LO, h, v);
                if (vs_w[d] && !prev_vs[d]) pop_cmp(d, EV_VS_HI, h, v);
                chk(d, "stb_align", 64'(h != prev_h[d]), 64'(stb_w[d]));
                if (stb_w[d]) begin
                    chk(d, "hold_clks", 64'(hold_m[d]), 64'(div_of[d]));
                    hold_m[d] = 1;
                end else begin
                    hold_m[d]++;
                end
            end
        end
        prev_von[d] = von_w[d];
        prev_hs[d]  = hs_w[d];
        prev_vs[d]  = vs_w[d];
        prev_h[d]   = h;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) monitor(d);
    end

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;

        // Default timing: lines 0-1, then a reset while (300,2) is shown, then one line after restart.
        gen(0, 2, 1600, 1280, 1312, 1504, 640, 656, 752, 480, 490, 492, 525);
        gen(0, 1, 1600, 1280, 1312, 1504, 640, 656, 752, 480, 490, 492, 525);
        // Small raster: two full frames (frame ticks at 720 and 1440).
        gen(1, 30, 48, 32, 36, 44, 16, 18, 22, 8, 10, 12, 15);
        // CLK_DIV=1 on default geometry: line ticks every 800 clk.
        gen(2, 3, 800, 640, 656, 752, 640, 656, 752, 480, 490, 492, 525);

        repeat (5) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Sample 3800 is the first clk showing (300,2); reset lands on the following edge.
        repeat (3801) @(posedge clk);
        #1 rst0 = 1'b1;
        @(posedge clk);
        #1 rst0 = 1'b0;

        repeat (1702) @(posedge clk);
        @(negedge clk);
        #1;
        chk(0, "missing_events", 64'(q0.size()), 64'd0);
        chk(1, "missing_events", 64'(q1.size()), 64'd0);
        chk(2, "missing_events", 64'(q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
